// File: rtl/arbitro_barramento.sv
// Round-robin arbiter/sequencer for the shared bidirectional Data bus.
// Optional ownership timeout enabled by defining ARBITRO_TIMEOUT_EN.
module arbitro_barramento #(
    parameter int NUM_MESTRES = 4,
    parameter int MAX_POSSE   = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_MESTRES-1:0] req,
    input  logic [NUM_MESTRES-1:0] dir,
    output logic [NUM_MESTRES-1:0] gnt,
    output logic [NUM_MESTRES-1:0] drv_en,
    output logic                   io,
    output logic                   ocupado,
    output logic                   fim
);

    localparam int IW = $clog2(NUM_MESTRES);
    localparam logic [NUM_MESTRES-1:0] UM = NUM_MESTRES'(1);

    if (NUM_MESTRES < 2 || NUM_MESTRES > 8 || MAX_POSSE < 1) begin : g_param_invalido
        $error("arbitro_barramento: invalid NUM_MESTRES or MAX_POSSE");
    end

    typedef enum logic [1:0] {LIVRE, VIRADA, POSSE} estado_t;

    estado_t       estado;
    logic [IW-1:0] vencedor;
    logic [IW-1:0] ponteiro;
    logic [IW-1:0] escolhido;
    logic          dir_lat;
    logic          estouro;

`ifdef ARBITRO_TIMEOUT_EN
    localparam int CW = $clog2(MAX_POSSE + 1);
    logic [CW-1:0] contador;
    // Revoke on the last allowed cycle so ownership is exactly MAX_POSSE cycles.
    assign estouro = (contador == CW'(MAX_POSSE - 1));
`else
    assign estouro = 1'b0;
`endif

    // First requester at or after ponteiro, with wrap-around.
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_v;
        logic          achou;
        escolhido = ponteiro;
        achou     = 1'b0;
        idx       = 0;
        idx_v     = '0;
        for (int i = 0; i < NUM_MESTRES; i++) begin
            idx = int'(ponteiro) + i;
            if (idx >= NUM_MESTRES) idx = idx - NUM_MESTRES;
            idx_v = IW'(idx);
            if (!achou && req[idx_v]) begin
                escolhido = idx_v;
                achou     = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= LIVRE;
            vencedor <= '0;
            ponteiro <= '0;
            dir_lat  <= 1'b0;
            gnt      <= '0;
            drv_en   <= '0;
            io       <= 1'b1;
            ocupado  <= 1'b0;
            fim      <= 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
            contador <= '0;
`endif
        end else begin
            fim <= 1'b0;
            case (estado)
                LIVRE: begin
                    if (|req) begin
                        vencedor <= escolhido;
                        dir_lat  <= dir[escolhido];
                        ocupado  <= 1'b1;
                        estado   <= VIRADA;
                    end
                end
                VIRADA: begin
                    // Dead cycle is over: the owner's driver may turn on now.
                    estado   <= POSSE;
                    ponteiro <= (vencedor == IW'(NUM_MESTRES - 1)) ? '0 : vencedor + 1'b1;
                    gnt      <= UM << vencedor;
                    drv_en   <= dir_lat ? (UM << vencedor) : '0;
                    io       <= dir_lat;
`ifdef ARBITRO_TIMEOUT_EN
                    contador <= '0;
`endif
                end
                POSSE: begin
                    if (!req[vencedor] || estouro) begin
                        estado  <= LIVRE;
                        gnt     <= '0;
                        drv_en  <= '0;
                        io      <= 1'b1;
                        ocupado <= 1'b0;
                        fim     <= 1'b1;
                    end
`ifdef ARBITRO_TIMEOUT_EN
                    else if (contador != CW'(MAX_POSSE)) begin
                        contador <= contador + 1'b1;
                    end
`endif
                end
                default: estado <= LIVRE;
            endcase
        end
    end

endmodule

// File: doc/arbitro_barramento.md
# arbitro_barramento

Round-robin arbiter and sequencer for the shared 16-bit bidirectional `Data` bus, which the temporary register reaches through its tri-state buffers. It grants the bus to one of `NUM_MESTRES` requesters at a time. It drives the temporary register's `io` direction line and one tri-state drive enable per requester. It enforces a dead turnaround cycle between owners so two drivers never overlap on `Data`.

## Interface
- `NUM_MESTRES`, 4: number of requesters, 2..8.
- `MAX_POSSE`, 8: maximum consecutive ownership cycles, ≥1; used only with `ARBITRO_TIMEOUT_EN`.
- `clock` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input NUM_MESTRES: per-requester bus request, level-held.
- `dir` input NUM_MESTRES: per-requester direction. 1 = requester drives `Data` and the temporary register captures. 0 = temporary register drives `Data` and the requester reads.
- `gnt` output NUM_MESTRES: one-hot grant, registered.
- `drv_en` output NUM_MESTRES: one-hot tri-state enable for the requester's `Data` driver, registered.
- `io` output 1: direction to the temporary register. 1 = temp register buffer off and capturing; 0 = temp register drives `Data`.
- `ocupado` output 1: high in VIRADA and POSSE.
- `fim` output 1: one-cycle pulse in the first cycle after an ownership ends.

## Operation
- State machine states: LIVRE (bus free), VIRADA (turnaround), POSSE (owner active).
- Internal registers:
  - `vencedor`: index of the winning requester.
  - `dir_lat`: `dir` latched at arbitration.
  - `ponteiro`: round-robin start index.
  - `contador`: ownership cycle count, width $clog2(MAX_POSSE+1).
- LIVRE:
  - If `req` ≠ 0, select the first set bit scanning from `ponteiro` upward with wrap-around.
  - Latch `vencedor` and `dir_lat = dir[vencedor]`, then go to VIRADA.
  - If `req` = 0, remain in LIVRE.
- VIRADA: lasts exactly one cycle.
  - `gnt` = 0, `drv_en` = 0, `io` = 1.
  - Go to POSSE.
  - Load `ponteiro` = (`vencedor`+1) mod NUM_MESTRES.
  - Clear `contador`.
- POSSE:
  - `gnt[vencedor]` = 1.
  - If `dir_lat` = 1: `drv_en[vencedor]` = 1, `io` = 1.
  - If `dir_lat` = 0: `drv_en` = 0, `io` = 0.
  - `contador` increments each cycle, saturating at MAX_POSSE.
- Leaving POSSE:
  - Condition: `req[vencedor]` = 0, or a timeout (see Configuration).
  - Next cycle: state LIVRE, `gnt` = 0, `drv_en` = 0, `io` = 1, `fim` = 1.
- Changes to `dir[vencedor]` during POSSE are ignored. Changes to other requesters' `req` during POSSE are ignored until LIVRE.
- Invariant: `drv_en` and `io` = 0 are never simultaneously active for the bus; at most one `drv_en` bit is ever set.

## Timing
- Reset values, asserted asynchronously on `reset_n` low:
  - state LIVRE; `gnt` = 0, `drv_en` = 0, `io` = 1, `ocupado` = 0, `fim` = 0.
  - `ponteiro` = 0, `contador` = 0, `vencedor` = 0, `dir_lat` = 0.
- Grant latency: `req` sampled high in LIVRE at edge N → VIRADA after edge N → `gnt` high after edge N+1.
- Release: `req[vencedor]` sampled low at edge M → `gnt`, `drv_en` low and `io` = 1 after edge M.
- Minimum gap between two owners is one LIVRE cycle plus one VIRADA cycle, i.e. two cycles with no driver.
- A requester that deasserts `req` in the same cycle LIVRE samples it high is still granted. It then releases one cycle into POSSE.
- When `req` is held high continuously by all requesters, grants rotate 0,1,2,…,NUM_MESTRES-1,0.
- Reset mid-POSSE: all drivers are released immediately (asynchronously) and `io` goes to 1.

## Configuration
- `ARBITRO_TIMEOUT_EN` defined:
  - POSSE also ends when `contador` reaches MAX_POSSE-1 with `req[vencedor]` still high. Ownership is therefore exactly MAX_POSSE cycles.
  - The revoked requester keeps its `req` and re-arbitrates normally. Since `ponteiro` has already advanced past it, other pending requesters win first.
- Not defined:
  - No `contador` logic is built. Ownership lasts until `req[vencedor]` drops; MAX_POSSE is unused.

## Test plan
- Reset with `req` = 4'b0000 → `gnt` = 0, `drv_en` = 0, `io` = 1, `ocupado` = 0 for 10 cycles.
- Single requester: `req` = 4'b0100, `dir` = 4'b0100, held 5 cycles then dropped → `gnt` = 4'b0100 and `drv_en` = 4'b0100 from cycle 2, `io` = 1 throughout. After `req` drops, `fim` pulses once.
- Read transfer: `req[1]` = 1 with `dir[1]` = 0 → `gnt` = 4'b0010, `drv_en` = 0, `io` = 0 in POSSE. `dir[1]` toggling mid-POSSE does not change `io`.
- All requesters held high, each dropping `req` 3 cycles after its grant → grant order 0,1,2,3,0, with exactly 2 dead cycles (`gnt` = 0) between owners.
- With `ARBITRO_TIMEOUT_EN`, MAX_POSSE = 8, `req` = 4'b0011 held high → `gnt[0]` for exactly 8 cycles, then `gnt[1]` for 8 cycles, alternating. Without the macro → `gnt[0]` is held indefinitely.
- `reset_n` pulsed low mid-POSSE with `drv_en` = 4'b1000 → `drv_en` = 0 and `io` = 1 before the next clock edge. After release, arbitration restarts from `ponteiro` = 0.
